// File: rtl/mem_stage_hs.sv
// EX->WB memory stage with a req/gnt + rsp_valid DMEM handshake, byte/word access and upstream stall.
// Optional: define MEM_STAGE_TIMEOUT_EN to abort accesses stuck waiting for gnt or rsp.
module mem_stage_hs #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES  = 15,
    localparam int LANES     = DMEM_WORD_WIDTH / 8,
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic                                 in_act_load_dmem,
    input  logic                                 in_act_store_dmem,
    input  logic                                 in_act_write_res_to_reg,
    input  logic                                 in_byte_access,
    input  logic                                 in_sign_ext,
    input  logic [DMEM_ADDR_WIDTH-1:0]           in_mem_addr,
    input  logic [DMEM_WORD_WIDTH-1:0]           in_mem_wr_word,
    input  logic [IALU_WORD_WIDTH-1:0]           in_res,
    input  logic [REG_IDX_WIDTH-1:0]             in_res_reg_idx,
    output logic                                 out_stall,
    output logic                                 out_dmem_req,
    output logic                                 out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-LANE_BITS-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0]           out_dmem_wr_word,
    output logic [LANES-1:0]                     out_dmem_byte_en,
    input  logic                                 in_dmem_gnt,
    input  logic                                 in_dmem_rsp_valid,
    input  logic [DMEM_WORD_WIDTH-1:0]           in_dmem_rd_word,
    output logic                                 out_valid,
    output logic                                 out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0]           out_res,
    output logic [REG_IDX_WIDTH-1:0]             out_res_reg_idx,
    output logic                                 out_mem_error
);

    if (IALU_WORD_WIDTH != DMEM_WORD_WIDTH) begin : g_width_chk
        $error("IALU_WORD_WIDTH must equal DMEM_WORD_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [DMEM_ADDR_WIDTH-1:0] addr;
        logic [DMEM_WORD_WIDTH-1:0] wdata;
        logic                       store;
        logic                       byte_acc;
        logic                       sext;
        logic                       wr_res;
        logic [REG_IDX_WIDTH-1:0]   idx;
    } mem_req_t;

    state_t   state;
    mem_req_t req_q;

    logic                       in_is_mem, in_misalign, st_req;
    logic [LANE_BITS-1:0]       lane;
    logic [7:0]                 rd_byte;
    logic [IALU_WORD_WIDTH-1:0] load_res;
    logic [LANES-1:0]           lane_onehot;

    assign in_is_mem   = in_act_load_dmem | in_act_store_dmem;
    assign in_misalign = (LANES > 1) && !in_byte_access && (in_mem_addr[LANE_BITS-1:0] != '0);

    assign lane        = req_q.addr[LANE_BITS-1:0];
    assign rd_byte     = in_dmem_rd_word[{lane, 3'b000} +: 8];
    assign load_res    = !req_q.byte_acc ? in_dmem_rd_word :
                         req_q.sext      ? {{(IALU_WORD_WIDTH-8){rd_byte[7]}}, rd_byte} :
                                           {{(IALU_WORD_WIDTH-8){1'b0}}, rd_byte};
    assign lane_onehot = LANES'(1) << lane;

    // DMEM side is decoded from state so reset drops the request in the same instant.
    assign out_stall        = (state != IDLE);
    assign out_dmem_req     = (state == REQ);
    assign st_req           = out_dmem_req & req_q.store;
    assign out_dmem_we      = st_req;
    assign out_dmem_addr    = out_dmem_req ? req_q.addr[DMEM_ADDR_WIDTH-1:LANE_BITS] : '0;
    assign out_dmem_wr_word = !st_req ? '0 :
                              req_q.byte_acc ? {LANES{req_q.wdata[7:0]}} : req_q.wdata;
    assign out_dmem_byte_en = !st_req ? '0 : req_q.byte_acc ? lane_onehot : '1;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= IDLE;
            req_q                    <= '0;
            out_valid                <= 1'b0;
            out_mem_error            <= 1'b0;
            out_act_write_res_to_reg <= 1'b0;
            out_res                  <= '0;
            out_res_reg_idx          <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            tmo_cnt                  <= '0;
`endif
        end else begin
            out_valid     <= 1'b0;
            out_mem_error <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
            case (state)
                IDLE: if (in_valid) begin
                    if (!in_is_mem) begin
                        out_valid                <= 1'b1;
                        out_res                  <= in_res;
                        out_res_reg_idx          <= in_res_reg_idx;
                        out_act_write_res_to_reg <= in_act_write_res_to_reg;
                    end else if (in_misalign) begin
                        out_valid                <= 1'b1;
                        out_mem_error            <= 1'b1;
                        out_res                  <= '0;
                        out_res_reg_idx          <= in_res_reg_idx;
                        out_act_write_res_to_reg <= 1'b0;
                    end else begin
                        // Load wins when both load and store are flagged.
                        req_q.addr     <= in_mem_addr;
                        req_q.wdata    <= in_mem_wr_word;
                        req_q.store    <= !in_act_load_dmem;
                        req_q.byte_acc <= in_byte_access;
                        req_q.sext     <= in_sign_ext;
                        req_q.wr_res   <= in_act_write_res_to_reg;
                        req_q.idx      <= in_res_reg_idx;
                        state          <= REQ;
                    end
                end
                REQ: if (in_dmem_gnt) begin
                    if (req_q.store) begin
                        out_valid                <= 1'b1;
                        out_res                  <= '0;
                        out_res_reg_idx          <= req_q.idx;
                        out_act_write_res_to_reg <= 1'b0;
                        state                    <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    out_valid                <= 1'b1;
                    out_mem_error            <= 1'b1;
                    out_res                  <= '0;
                    out_res_reg_idx          <= req_q.idx;
                    out_act_write_res_to_reg <= 1'b0;
                    state                    <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
`endif
                WAIT: if (in_dmem_rsp_valid) begin
                    out_valid                <= 1'b1;
                    out_res                  <= load_res;
                    out_res_reg_idx          <= req_q.idx;
                    out_act_write_res_to_reg <= req_q.wr_res;
                    state                    <= IDLE;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    out_valid                <= 1'b1;
                    out_mem_error            <= 1'b1;
                    out_res                  <= '0;
                    out_res_reg_idx          <= req_q.idx;
                    out_act_write_res_to_reg <= 1'b0;
                    state                    <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation memory pipeline stage for the swt16 core, sitting between EX and WB. Unlike the fixed single-cycle stage, it talks to DMEM through a req/gnt + rsp_valid handshake with variable latency. It supports byte and word accesses with sign/zero extension and stalls upstream while an access is outstanding. Non-memory results still pass through with one-cycle latency.

Parameters:
DMEM_ADDR_WIDTH, 12, byte address width presented by EX
DMEM_WORD_WIDTH, 16, DMEM data width; multiple of 8; LANES = DMEM_WORD_WIDTH/8, LANE_BITS = clog2(LANES) (min 1)
IALU_WORD_WIDTH, 16, result width; must equal DMEM_WORD_WIDTH
REG_IDX_WIDTH, 4, register index width
TIMEOUT_CYCLES, 15, max cycles waiting for gnt or rsp (only with MEM_STAGE_TIMEOUT_EN)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  EX presents an instruction
in_act_load_dmem  in  1  load
in_act_store_dmem  in  1  store (load and store both high: treated as load)
in_act_write_res_to_reg  in  1  result goes to register file
in_byte_access  in  1  1 = byte, 0 = full word
in_sign_ext  in  1  byte load sign-extends when 1
in_mem_addr  in  DMEM_ADDR_WIDTH  byte address
in_mem_wr_word  in  DMEM_WORD_WIDTH  store data; byte stores use bits [7:0]
in_res  in  IALU_WORD_WIDTH  ALU result
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
out_stall  out  1  upstream must hold inputs
out_dmem_req  out  1  DMEM request
out_dmem_we  out  1  1 = write
out_dmem_addr  out  DMEM_ADDR_WIDTH-LANE_BITS  word address
out_dmem_wr_word  out  DMEM_WORD_WIDTH  lane-replicated write data
out_dmem_byte_en  out  LANES  write lane enables
in_dmem_gnt  in  1  request accepted
in_dmem_rsp_valid  in  1  read data valid
in_dmem_rd_word  in  DMEM_WORD_WIDTH  read data
out_valid  out  1  WB outputs valid (1-cycle pulse per instruction)
out_act_write_res_to_reg  out  1  WB write enable
out_res  out  IALU_WORD_WIDTH  result to WB
out_res_reg_idx  out  REG_IDX_WIDTH  destination to WB
out_mem_error  out  1  misaligned access or timeout (pulse, aligned with out_valid)

Behaviour:
- Reset: state IDLE; every output 0; timeout counter 0. Reset mid-access drops out_dmem_req immediately and discards the access; no out_valid follows.
- States: IDLE, REQ, WAIT. out_stall = (state != IDLE), combinational.
- Inputs are sampled only in IDLE with in_valid=1.
- Non-memory op (no load/store): on the next edge, out_valid=1 and outputs = sampled in_res, idx, write flag. Latency 1. State stays IDLE.
- Memory op: capture addr, data, flags, idx, then go to REQ. Exception: word access with addr[LANE_BITS-1:0]!=0. In that case there is no DMEM request; next cycle out_valid=1, out_mem_error=1, out_res=0, out_act_write_res_to_reg=0.
- REQ: out_dmem_req=1 and out_dmem_addr = addr>>LANE_BITS, held stable until in_dmem_gnt.
  - Store + gnt: we=1, byte_en = all ones for word, one-hot at the lane for byte; wr_word = byte replicated across lanes for byte stores. Next cycle out_valid=1, write flag forced 0; state IDLE.
  - Load + gnt: go to WAIT. in_dmem_rsp_valid in the same cycle as gnt is ignored.
- WAIT: on in_dmem_rsp_valid, word load returns rd_word. Byte load takes the lane byte, sign- or zero-extended. Next cycle out_valid=1 with captured idx and write flag; state IDLE.
- Minimum load latency with gnt and rsp on consecutive cycles: 3 cycles from acceptance to out_valid.
- Back-to-back: completion cycle has out_stall=0, so the next instruction is accepted that cycle.
- out_valid, out_mem_error are 1-cycle pulses. out_res, out_res_reg_idx, out_act_write_res_to_reg hold until the next out_valid.

Optional Feature:
MEM_STAGE_TIMEOUT_EN
- Defined: counter increments each cycle in REQ/WAIT and clears on gnt, rsp or leaving the state. Reaching TIMEOUT_CYCLES aborts the access: req drops, next cycle out_valid=1, out_mem_error=1, out_res=0, write flag 0; state IDLE.
- Undefined: no counter; stage waits indefinitely; out_mem_error reports only misalignment.

Test Plan:
- ALU pass-through: in_valid, in_res=0x1234, idx=3, write=1 -> next cycle out_valid=1, out_res=0x1234, idx=3, out_stall never high.
- Word load, gnt after 2 cycles, rsp 1 cycle later with 0xBEEF, addr=0x010 -> out_dmem_addr=0x008 held stable; out_res=0xBEEF; out_stall high throughout.
- Byte load addr=0x011, rd_word=0x80AA: sign_ext=1 -> out_res=0xFF80; sign_ext=0 -> 0x0080.
- Byte store 0x5A to addr=0x003 -> byte_en=2'b10, wr_word=0x5A5A, we=1; out_valid with write flag 0.
- Misaligned word load addr=0x005 -> no out_dmem_req; out_mem_error=1, write flag 0. Reset asserted in WAIT -> req 0 at once and no out_valid.
- With MEM_STAGE_TIMEOUT_EN, gnt never asserted -> after 15 cycles out_mem_error=1, out_res=0; next instruction accepted.
